// File: rtl/mutation_engine_if.sv
// Run control, parent paths and child paths of the genetic mutation stage.
// Latency: none, this only groups signals.
// Backpressure: none; start is a level that the engine samples only while idle.
interface mutation_engine_if #(
  parameter int NODE_BITS = 5,
  parameter int NODES     = 30,
  parameter int PARENTS   = 10,
  parameter int FAMILY    = 5
) ();
  localparam int PATH_BITS = NODES * NODE_BITS;

  logic                                start;
  logic [7:0]                          mut_rate;
  logic [31:0]                         prg_seed;
  logic [PARENTS*PATH_BITS-1:0]        sel_population;
  logic [PARENTS*FAMILY*PATH_BITS-1:0] mutant_pop;
  logic                                busy;
  logic                                done;

  modport master (
    output start, mut_rate, prg_seed, sel_population,
    input  mutant_pop, busy, done
  );

  modport slave (
    input  start, mut_rate, prg_seed, sel_population,
    output mutant_pop, busy, done
  );
endinterface

// File: rtl/mutation_engine.sv
// Builds FAMILY children per parent path: child 0 is an exact copy, the rest get SWAPS LFSR-driven swap attempts.
// Latency: PARENTS*(2*FAMILY + (FAMILY-1)*SWAPS) busy cycles after start, then a one-cycle done pulse.
// Backpressure: none; start is ignored unless idle and sel_population must stay stable while busy.
module mutation_engine #(
  parameter int NODE_BITS = 5,
  parameter int NODES     = 30,
  parameter int PARENTS   = 10,
  parameter int FAMILY    = 5,
  parameter int SWAPS     = 4
) (
  input logic              clk,
  input logic              rst,
  mutation_engine_if.slave bus
);
  localparam int PATH_BITS = NODES * NODE_BITS;
  localparam int SLOTS     = PARENTS * FAMILY;
  localparam int IDX_BITS  = $clog2(NODES);
  localparam int PROD_BITS = 8 + IDX_BITS;
  localparam int P_BITS    = (PARENTS > 1) ? $clog2(PARENTS) : 1;
  localparam int C_BITS    = (FAMILY > 1) ? $clog2(FAMILY) : 1;
  localparam int S_BITS    = (SWAPS > 1) ? $clog2(SWAPS) : 1;
  localparam int SLOT_BITS = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, LOAD, MUTATE, STORE, DONE} state_t;

  state_t                      state, state_nxt;
  logic [P_BITS-1:0]           p_cnt;
  logic [C_BITS-1:0]           c_cnt;
  logic [S_BITS-1:0]           s_cnt;
  logic [7:0]                  rate_q;
  logic [31:0]                 lfsr;
  logic [31:0]                 lfsr_nxt;
  logic [NODE_BITS-1:0]        work [NODES];
  logic [PATH_BITS-1:0]        work_flat;
  logic [PATH_BITS-1:0]        parent_path;
  logic [SLOTS*PATH_BITS-1:0]  pop_q;
  logic [SLOT_BITS-1:0]        slot;
  logic [IDX_BITS-1:0]         idx_i, idx_j;
  logic                        do_swap;
  logic                        last_swap, last_child, last_parent;
  logic                        busy_c, done_c;

  assign last_swap   = (s_cnt == S_BITS'(SWAPS - 1));
  assign last_child  = (c_cnt == C_BITS'(FAMILY - 1));
  assign last_parent = (p_cnt == P_BITS'(PARENTS - 1));
  assign slot        = SLOT_BITS'(p_cnt) * SLOT_BITS'(FAMILY) + SLOT_BITS'(c_cnt);

  // Galois right-shift step; the register only takes it in MUTATE.
  assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);

  // Scale a random byte onto the interior 1..NODES-2; full-width product keeps the mapping exact.
  assign idx_i   = IDX_BITS'((PROD_BITS'(lfsr[15:8]) * PROD_BITS'(NODES - 2)) >> 8) + IDX_BITS'(1);
  assign idx_j   = IDX_BITS'((PROD_BITS'(lfsr[23:16]) * PROD_BITS'(NODES - 2)) >> 8) + IDX_BITS'(1);
  assign do_swap = (lfsr[7:0] < rate_q);

  // Pick the parent currently being worked on.
  always_comb begin
    parent_path = '0;
    for (int pp = 0; pp < PARENTS; pp++) begin
      if (p_cnt == P_BITS'(pp)) parent_path = bus.sel_population[pp*PATH_BITS +: PATH_BITS];
    end
  end

  // Flatten the working path for storing into its output slot.
  always_comb begin
    work_flat = '0;
    for (int k = 0; k < NODES; k++) work_flat[k*NODE_BITS +: NODE_BITS] = work[k];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and status outputs.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nxt = LOAD;
      LOAD: begin
        busy_c    = 1'b1;
        state_nxt = (c_cnt != '0) ? MUTATE : STORE;
      end
      MUTATE: begin
        busy_c = 1'b1;
        if (last_swap) state_nxt = STORE;
      end
      STORE: begin
        busy_c    = 1'b1;
        state_nxt = (last_child && last_parent) ? DONE : LOAD;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.mutant_pop = pop_q;

  // Run counters, latched rate and the LFSR; seed 0 would lock the LFSR so it becomes 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_cnt  <= '0;
      c_cnt  <= '0;
      s_cnt  <= '0;
      rate_q <= 8'h0;
      lfsr   <= 32'h1;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          p_cnt  <= '0;
          c_cnt  <= '0;
          s_cnt  <= '0;
          rate_q <= bus.mut_rate;
          lfsr   <= (bus.prg_seed == 32'h0) ? 32'h1 : bus.prg_seed;
        end
        MUTATE: begin
          lfsr  <= lfsr_nxt;
          s_cnt <= last_swap ? '0 : s_cnt + S_BITS'(1);
        end
        STORE: begin
          if (!last_child) begin
            c_cnt <= c_cnt + C_BITS'(1);
          end else if (!last_parent) begin
            c_cnt <= '0;
            p_cnt <= p_cnt + P_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Working path: loaded from the parent, then interior nodes swapped; i==j is a harmless no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NODES; k++) work[k] <= '0;
    end else if (state == LOAD) begin
      for (int k = 0; k < NODES; k++) work[k] <= parent_path[k*NODE_BITS +: NODE_BITS];
    end else if (state == MUTATE && do_swap) begin
      work[idx_i] <= work[idx_j];
      work[idx_j] <= work[idx_i];
    end
  end

  // Output population: only the slot being stored changes, all others hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q <= '0;
    end else if (state == STORE) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (slot == SLOT_BITS'(k)) pop_q[k*PATH_BITS +: PATH_BITS] <= work_flat;
      end
    end
  end
endmodule

// File: tb/tb_mutation_engine.sv
// Scoreboard bench for mutation_engine: default-size and small-size instances.
// Latency: expected done cycle is pushed with each run and checked when done pulses.
// Backpressure: none; stimulus and monitors are decoupled by queues.
module tb_mutation_engine;
  localparam int BP = 10, BF = 5, BN = 30, BB = 5, BS = 4;
  localparam int BL = BP * (2*BF + (BF-1)*BS);   // 260
  localparam int SP = 2, SF = 3, SN = 8, SB = 3, SS = 2;
  localparam int SL = SP * (2*SF + (SF-1)*SS);   // 20
  localparam int POPW = BP * BF * BN * BB;
  typedef logic [POPW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  vec_t big_exp_q[$], big_par_q[$], sml_exp_q[$], sml_par_q[$];
  int   big_cyc_q[$], sml_cyc_q[$];
  bit   big_perm_q[$], sml_perm_q[$];
  vec_t big_par, sml_par, gold_b;
  int   acc;

  mutation_engine_if #(.NODE_BITS(BB), .NODES(BN), .PARENTS(BP), .FAMILY(BF)) bif ();
  mutation_engine_if #(.NODE_BITS(SB), .NODES(SN), .PARENTS(SP), .FAMILY(SF)) sif ();

  mutation_engine #(.NODE_BITS(BB), .NODES(BN), .PARENTS(BP), .FAMILY(BF), .SWAPS(BS))
    u_big (.clk(clk), .rst(rst), .bus(bif));
  mutation_engine #(.NODE_BITS(SB), .NODES(SN), .PARENTS(SP), .FAMILY(SF), .SWAPS(SS))
    u_sml (.clk(clk), .rst(rst), .bus(sif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int get_node(input vec_t v, input int nb, input int idx);
    int x = 0;
    for (int b = 0; b < nb; b++) if (v[idx*nb + b]) x = x | (1 << b);
    return x;
  endfunction

  // Reference model of a whole run.
  function automatic vec_t model(input vec_t par, input int np, nf, nn, ns, nb,
                                 input int rate, input logic [31:0] seed);
    vec_t        out = '0;
    int          w [BN];
    int          i, j, t;
    logic [31:0] r;
    r = (seed == 32'h0) ? 32'h1 : seed;
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < nf; c++) begin
        for (int k = 0; k < nn; k++) w[k] = get_node(par, nb, p*nn + k);
        if (c != 0) begin
          for (int s = 0; s < ns; s++) begin
            if (int'(r[7:0]) < rate) begin
              i = 1 + ((int'(r[15:8]) * (nn - 2)) / 256);
              j = 1 + ((int'(r[23:16]) * (nn - 2)) / 256);
              t = w[i]; w[i] = w[j]; w[j] = t;
            end
            r = lfsr_step(r);
          end
        end
        for (int k = 0; k < nn; k++)
          for (int b = 0; b < nb; b++) out[((p*nf + c)*nn + k)*nb + b] = w[k][b];
      end
    end
    return out;
  endfunction

  // Rate 0: every child is just its parent.
  function automatic vec_t copies(input vec_t par, input int np, nf, pw);
    vec_t out = '0;
    for (int p = 0; p < np; p++)
      for (int c = 0; c < nf; c++)
        for (int b = 0; b < pw; b++) out[(p*nf + c)*pw + b] = par[p*pw + b];
    return out;
  endfunction

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_run(input string tag, input vec_t got, input vec_t exp, input vec_t par,
                           input bit perm, input int np, nf, nn, nb, input int now, input int exp_cyc);
    int bad_slot, slot, g, e;
    int hist [32];
    checks++;
    if (now != exp_cyc) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d, expected %0d", tag, now, exp_cyc);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      bad_slot = -1;
      for (int k = 0; k < np*nf*nn && bad_slot < 0; k++)
        if (get_node(got, nb, k) != get_node(exp, nb, k)) begin
          bad_slot = k;
          g = get_node(got, nb, k);
          e = get_node(exp, nb, k);
        end
      $display("FAIL %s mutant_pop: slot %0d node %0d got %0d, expected %0d",
               tag, bad_slot / nn, bad_slot % nn, g, e);
    end
    if (perm) begin
      bad_slot = -1;
      for (int p = 0; p < np; p++) begin
        for (int c = 0; c < nf; c++) begin
          slot = p*nf + c;
          for (int k = 0; k < 32; k++) hist[k] = 0;
          for (int k = 0; k < nn; k++) begin
            hist[get_node(par, nb, p*nn + k)]++;
            hist[get_node(got, nb, slot*nn + k)]--;
            if (c == 0 && get_node(par, nb, p*nn + k) != get_node(got, nb, slot*nn + k)) bad_slot = slot;
          end
          for (int k = 0; k < 32; k++) if (hist[k] != 0) bad_slot = slot;
          if (get_node(got, nb, slot*nn) != get_node(par, nb, p*nn)) bad_slot = slot;
          if (get_node(got, nb, slot*nn + nn - 1) != get_node(par, nb, p*nn + nn - 1)) bad_slot = slot;
        end
      end
      checks++;
      if (bad_slot >= 0) begin
        errors++;
        $display("FAIL %s permutation: slot %0d broke endpoints/multiset/elitism, expected none", tag, bad_slot);
      end
    end
  endtask

  // Monitor for the default-size instance.
  always @(negedge clk) begin
    if (!rst && bif.done) begin
      if (big_cyc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL big unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        check_run("big", bif.mutant_pop, big_exp_q.pop_front(), big_par_q.pop_front(),
                  big_perm_q.pop_front(), BP, BF, BN, BB, cyc, big_cyc_q.pop_front());
      end
    end
  end

  // Monitor for the small instance.
  always @(negedge clk) begin
    if (!rst && sif.done) begin
      if (sml_cyc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL small unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        check_run("small", vec_t'(sif.mutant_pop), sml_exp_q.pop_front(), sml_par_q.pop_front(),
                  sml_perm_q.pop_front(), SP, SF, SN, SB, cyc, sml_cyc_q.pop_front());
      end
    end
  end

  task automatic push_big(input vec_t e, input int dc, input bit perm);
    big_exp_q.push_back(e); big_par_q.push_back(big_par);
    big_cyc_q.push_back(dc); big_perm_q.push_back(perm);
  endtask

  task automatic start_big(input logic [7:0] rate, input logic [31:0] seed, output int a);
    bif.mut_rate = rate; bif.prg_seed = seed; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    a = cyc;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((big_cyc_q.size() + sml_cyc_q.size()) != 0 && n < 700) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((big_cyc_q.size() + sml_cyc_q.size()) != 0) begin
      errors++;
      $display("FAIL %s timeout: got %0d runs pending, expected 0", name, big_cyc_q.size() + sml_cyc_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    big_par = '0;
    sml_par = '0;
    for (int p = 0; p < BP; p++)
      for (int k = 0; k < BN; k++) begin
        int v = (k*7 + p*3) % BN;
        for (int b = 0; b < BB; b++) big_par[(p*BN + k)*BB + b] = v[b];
      end
    for (int p = 0; p < SP; p++)
      for (int k = 0; k < SN; k++) begin
        int v = (k*3 + p) % SN;
        for (int b = 0; b < SB; b++) sml_par[(p*SN + k)*SB + b] = v[b];
      end
    gold_b = model(big_par, BP, BF, BN, BS, BB, 255, 32'hACE1);

    rst = 1'b1;
    bif.start = 1'b0; bif.mut_rate = 8'h0; bif.prg_seed = 32'h0;
    bif.sel_population = big_par[BP*BN*BB-1:0];
    sif.start = 1'b0; sif.mut_rate = 8'h0; sif.prg_seed = 32'h0;
    sif.sel_population = sml_par[SP*SN*SB-1:0];
    repeat (3) @(negedge clk);
    chk("reset_pop",  bif.mutant_pop == '0, 1'b1);
    chk("reset_busy", bif.busy, 1'b0);
    chk("reset_done", bif.done, 1'b0);
    chk("reset_small_pop", sif.mutant_pop == '0, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Copy run: rate 0, busy over cycles 1..260, done at 261.
    start_big(8'd0, 32'h1234, acc);
    push_big(copies(big_par, BP, BF, BN*BB), acc + BL, 1'b1);
    chk("copy_busy_c1", bif.busy, 1'b1);
    wait_to(acc + BL - 1);
    chk("copy_busy_c260", bif.busy, 1'b1);
    wait_to(acc + BL);
    chk("copy_busy_c261", bif.busy, 1'b0);
    drain("copy");

    // Full mutation.
    start_big(8'd255, 32'hACE1, acc);
    push_big(gold_b, acc + BL, 1'b1);
    drain("full");

    // Seed 0 behaves exactly as seed 1.
    start_big(8'd128, 32'h0, acc);
    push_big(model(big_par, BP, BF, BN, BS, BB, 128, 32'h1), acc + BL, 1'b1);
    drain("seed0");
    start_big(8'd128, 32'h1, acc);
    push_big(model(big_par, BP, BF, BN, BS, BB, 128, 32'h1), acc + BL, 1'b1);
    drain("seed1");

    // Start pulses while busy and during DONE are ignored; new rate/seed not latched.
    start_big(8'd255, 32'hACE1, acc);
    push_big(gold_b, acc + BL, 1'b0);
    wait_to(acc + 49);
    bif.mut_rate = 8'd0; bif.prg_seed = 32'h7; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    wait_to(acc + BL);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    wait_to(acc + 2*BL + 20);
    drain("busy_start");

    // Reset at cycle 100 clears everything on the next cycle.
    start_big(8'd255, 32'hACE1, acc);
    wait_to(acc + 99);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pop",  bif.mutant_pop == '0, 1'b1);
    chk("midrst_busy", bif.busy, 1'b0);
    chk("midrst_done", bif.done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    start_big(8'd255, 32'hACE1, acc);
    push_big(gold_b, acc + BL, 1'b0);
    drain("after_rst");

    // start held high: second run accepted on the first IDLE cycle, with the seed present then.
    bif.mut_rate = 8'd255; bif.prg_seed = 32'h5; bif.start = 1'b1;
    @(negedge clk);
    acc = cyc;
    push_big(model(big_par, BP, BF, BN, BS, BB, 255, 32'h5), acc + BL, 1'b1);
    @(negedge clk);
    bif.prg_seed = 32'h9;
    push_big(model(big_par, BP, BF, BN, BS, BB, 255, 32'h9), acc + 2*BL + 2, 1'b1);
    wait_to(acc + BL + 2);
    bif.start = 1'b0;
    drain("held_start");

    // Small geometry: L = 20, done at cycle 21, indices confined to 1..6.
    sif.mut_rate = 8'd255; sif.prg_seed = 32'hACE1; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    acc = cyc;
    sml_exp_q.push_back(model(sml_par, SP, SF, SN, SS, SB, 255, 32'hACE1));
    sml_par_q.push_back(sml_par);
    sml_cyc_q.push_back(acc + SL);
    sml_perm_q.push_back(1'b1);
    drain("small");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mutation_engine.md
# mutation_engine

Parametrised mutation stage of the genetic path optimiser. It takes the selected parent paths and produces a family of children per parent. Child 0 of every family is an unmutated copy (elitism). The other children receive a programmable number of random swap attempts on interior nodes, gated by a run-time mutation rate. All children are built sequentially through one datapath driven by a single seeded LFSR, so results are reproducible from the seed.

## Interface
- NODE_BITS, 5, width of one node (city) index
- NODES, 30, nodes per path; PATH_BITS = NODES*NODE_BITS (150)
- PARENTS, 10, parent paths in sel_population
- FAMILY, 5, children per parent (≥1); output holds PARENTS*FAMILY paths
- SWAPS, 4, swap attempts per mutated child (≥1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- mut_rate  in  8  swap probability numerator; latched at start
- prg_seed  in  32  LFSR seed; latched at start
- sel_population  in  PARENTS*PATH_BITS  parent p at [p*PATH_BITS +: PATH_BITS]; must be stable while busy
- mutant_pop  out  PARENTS*FAMILY*PATH_BITS  child (p,c) at [(p*FAMILY+c)*PATH_BITS +: PATH_BITS]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when all children are written

## Operation
- States: IDLE, LOAD, MUTATE, STORE, DONE. Counters: p (0..PARENTS-1), c (0..FAMILY-1), s (0..SWAPS-1).
- IDLE + start transitions to LOAD with p=c=0. On the same edge:
  - latch mut_rate;
  - load LFSR with prg_seed (0 is replaced by 32'h1).
- LOAD: work ← parent p. Next state is MUTATE if c≠0, else STORE.
- MUTATE: one swap attempt per cycle, SWAPS cycles total, using the current LFSR value r.
  - Swap if r[7:0] < mut_rate. mut_rate=0 never swaps; 255 swaps with probability 255/256.
  - i = 1 + ((r[15:8]*(NODES-2)) >> 8); j = 1 + ((r[23:16]*(NODES-2)) >> 8). Products are 8+clog2(NODES) bits, no truncation before the shift.
  - Node 0 and node NODES-1 are never moved; path endpoints are fixed.
  - i==j leaves the path unchanged but still counts as an attempt.
  - The LFSR advances exactly once per MUTATE cycle and at no other time.
- LFSR: 32-bit Galois, right shift, feedback mask 32'h80200003 applied when the shifted-out bit is 1.
- STORE: mutant_pop slot (p,c) ← work. Then:
  - if c<FAMILY-1: c++, go to LOAD;
  - else if p<PARENTS-1: c=0, p++, go to LOAD;
  - else go to DONE.
- DONE: done=1 for one cycle, then IDLE. mutant_pop holds until overwritten by the next run.
- A run only permutes nodes, so every child has the same node multiset as its parent.
- start is ignored outside IDLE. start asserted during the DONE cycle is also ignored.

## Timing
- Reset values: mutant_pop=0, done=0, busy=0, state=IDLE, LFSR=32'h1, latched rate=0.
- rst mid-run: IDLE on the next edge. Outputs return to reset values; partially written slots are cleared.
- Run length from the accepting edge: L = PARENTS*(2*FAMILY + (FAMILY-1)*SWAPS) cycles in LOAD/MUTATE/STORE. done is high in cycle L+1.
- Default parameters: L=260; done is high 261 cycles after the start edge.
- Slot (p,c) is updated on its STORE edge. Slots still to be written keep their previous-run values during a run.
- busy is low in IDLE and in DONE.
- start may be held high continuously: it is re-accepted on the first IDLE cycle after DONE.

## Test plan
- Copy check: mut_rate=0, any seed, distinct parents → all 50 children equal their parent; done pulses exactly once at cycle 261; busy high cycles 1–260.
- Full mutation: mut_rate=255, seed=32'hACE1 → in every child node 0 and node 29 are unchanged and the node multiset is preserved; child 0 of each family equals its parent; output matches the C reference model bit-exactly.
- Zero seed: seed=0 and seed=1 with rate=128 → identical mutant_pop.
- Busy start: pulse start again at cycle 50 and cycle 261 → ignored; single done; output identical to an undisturbed run.
- Reset mid-run: rst at cycle 100 → mutant_pop=0, busy=0, done=0 next cycle. A fresh start then reproduces the golden output.
- Small parameters: PARENTS=2, FAMILY=3, NODES=8, NODE_BITS=3, SWAPS=2, mut_rate=255 → done at cycle 21 (L=20); index range is 1..6 only; output matches the model.
